booth_seq_mult_4bit: RTL and testbench
======================================

BOOTH_SEQ_MULT_4BIT -- requirements
Module: booth_seq_mult_4bit

Interface
REQ-001 SHALL have parameter N, default 4, signed operand width; only N=4 is supported.
REQ-002 SHALL have port clk  input  1  single clock, rising-edge active.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  N  signed multiplicand.
REQ-007 SHALL have port b  input  N  signed multiplier, Booth-recoded.
REQ-008 SHALL have port out_valid  output  1  product available.
REQ-009 SHALL have port out_ready  input  1  downstream accepts product.
REQ-010 SHALL have port product  output  2N  signed product a*b.
REQ-011 SHALL have port busy  output  1  high in CALC or DONE.

Function
REQ-012 SHALL use FSM states IDLE, CALC, DONE.
REQ-013 SHALL assert in_ready only in IDLE.
REQ-014 SHALL, in IDLE with in_valid=1, capture a and b, clear accumulator and group index, and go to CALC.
REQ-015 SHALL, in CALC, process one radix-4 group per cycle, index i=0 then i=1.
REQ-016 SHALL form group i as {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
REQ-017 SHALL decode groups as: 000/111 -> 0; 001/010 -> +a; 011 -> +2a; 100 -> -2a; 101/110 -> -a; result is a 6-bit signed partial product.
REQ-018 SHALL sign-extend each partial product to 2N bits, shift it left by 2i, and add it to the accumulator modulo 2^(2N).
REQ-019 SHALL go to DONE after group 1; accept-to-out_valid latency is 3 cycles.
REQ-020 SHALL, in DONE, hold out_valid=1 and product stable until out_ready=1, then return to IDLE on that edge.
REQ-021 SHALL make product equal to the exact signed a*b for all 256 operand pairs; range is -56..64.
REQ-022 SHALL ignore in_valid outside IDLE, so operands never change mid-operation.
REQ-023 SHALL deassert in_ready in the cycle after leaving DONE, i.e. no same-cycle accept; throughput is one result per 4 cycles when out_ready=1.
REQ-024 SHALL keep product at its last value in IDLE and CALC and qualify it only by out_valid.

Reset
REQ-025 SHALL, on rst_n=0, immediately force state=IDLE, in_ready=1 (after deassert), out_valid=0, busy=0, product=0, accumulator=0, group index=0.
REQ-026 SHALL abort any in-progress operation on reset mid-CALC or mid-DONE and discard the result.

Structure
REQ-027 SHALL place the state encoding (IDLE, CALC, DONE), N, and Booth group code constants in shared package booth_pkg.
REQ-028 SHALL instantiate the existing radix-4 4-bit Booth partial-product generator booth_pp_radix4_4bit once, driven by the current group.
REQ-029 SHALL keep the accumulator, FSM and handshake logic in this module; all registers use the async active-low reset.

Verification
REQ-030 SHALL verify: a=3, b=5 with out_ready=1 -> product=15, out_valid rises 3 cycles after accept, held 1 cycle.
REQ-031 SHALL verify: a=-8, b=-8 -> product=64; a=-8, b=7 -> product=-56; a=7, b=-1 -> product=-7.
REQ-032 SHALL verify: out_ready=0 for 5 cycles in DONE -> out_valid and product stable, in_ready=0 throughout, new in_valid ignored.
REQ-033 SHALL verify: rst_n pulsed low in the CALC cycle for a=5, b=6 -> out_valid=0, product=0 immediately; next accepted a=2, b=-3 -> -6.
REQ-034 SHALL verify: exhaustive 256-pair sweep with random out_ready stalls -> every product matches the reference a*b, in order, no drops or duplicates.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier: operand width,
// FSM state encoding and the Booth group codes with their decode.
package booth_pkg;

   localparam int BOOTH_N = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] GRP_000 = 3'b000;
   localparam logic [2:0] GRP_001 = 3'b001;
   localparam logic [2:0] GRP_010 = 3'b010;
   localparam logic [2:0] GRP_011 = 3'b011;
   localparam logic [2:0] GRP_100 = 3'b100;
   localparam logic [2:0] GRP_101 = 3'b101;
   localparam logic [2:0] GRP_110 = 3'b110;
   localparam logic [2:0] GRP_111 = 3'b111;

   typedef enum logic [2:0] {
      OP_ZERO = 3'd0,
      OP_ADD1 = 3'd1,
      OP_ADD2 = 3'd2,
      OP_SUB2 = 3'd3,
      OP_SUB1 = 3'd4
   } pp_op_t;

   // Maps a 3-bit Booth group {b[2i+1], b[2i], b[2i-1]} to its multiple of a.
   function automatic pp_op_t decode_group(input logic [2:0] grp);
      pp_op_t op;
      case (grp)
         GRP_000, GRP_111: op = OP_ZERO;
         GRP_001, GRP_010: op = OP_ADD1;
         GRP_011:          op = OP_ADD2;
         GRP_100:          op = OP_SUB2;
         GRP_101, GRP_110: op = OP_SUB1;
         default:          op = OP_ZERO;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/booth_pp_radix4_4bit.sv
// Radix-4 Booth partial-product generator for a 4-bit signed multiplicand;
// produces a 6-bit signed partial product in {0, +a, +2a, -2a, -a}.
module booth_pp_radix4_4bit
   import booth_pkg::*;
(
   input  logic [3:0] a,
   input  logic [2:0] grp,
   output logic [5:0] pp
);

   logic [5:0] a_ext;

   assign a_ext = {{2{a[3]}}, a};

   always_comb begin
      // NOTE: default assignment first so every path drives pp and no latch is inferred.
      pp = '0;
      case (decode_group(grp))
         OP_ADD1: pp = a_ext;
         OP_ADD2: pp = a_ext << 1;
         OP_SUB2: pp = -(a_ext << 1);
         OP_SUB1: pp = -a_ext;
         default: pp = '0;
      endcase
   end

endmodule

// File: rtl/booth_seq_mult_4bit.sv
// Sequential signed multiplier: one radix-4 Booth group per cycle, valid/ready
// on both sides, product held in DONE until the consumer takes it.
module booth_seq_mult_4bit
   import booth_pkg::*;
#(
   parameter int N = BOOTH_N
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] product,
   output logic           busy
);

   state_t         state;
   logic [N-1:0]   a_r;
   logic [N-1:0]   b_r;
   logic [2*N-1:0] acc;
   logic           grp_idx;

   logic [N:0]     b_ext;
   logic [2:0]     grp;
   logic [N+1:0]   pp;
   logic [2*N-1:0] pp_ext;
   logic [2*N-1:0] pp_term;
   logic [2*N-1:0] acc_next;

   // b[-1] is the implicit zero below the LSB, so group i starts at b_ext[2i].
   assign b_ext = {b_r, 1'b0};
   assign grp   = b_ext[{grp_idx, 1'b0} +: 3];

   booth_pp_radix4_4bit u_pp (
      .a   (a_r),
      .grp (grp),
      .pp  (pp)
   );

   assign pp_ext   = {{(N-2){pp[N+1]}}, pp};
   assign pp_term  = grp_idx ? (pp_ext << 2) : pp_ext;
   assign acc_next = acc + pp_term;

   // NOTE: all state is updated with non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: datapath registers are reset too, so product reads 0 after an abort.
         state     <= IDLE;
         a_r       <= '0;
         b_r       <= '0;
         acc       <= '0;
         grp_idx   <= 1'b0;
         product   <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r      <= a;
                  b_r      <= b;
                  acc      <= '0;
                  grp_idx  <= 1'b0;
                  state    <= CALC;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            CALC: begin
               acc     <= acc_next;
               grp_idx <= 1'b1;
               if (grp_idx) begin
                  grp_idx   <= 1'b0;
                  product   <= acc_next;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               // in_ready only rises after the edge that leaves DONE: no same-cycle accept.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               grp_idx   <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_seq_mult_4bit.sv
// Scoreboard bench for booth_seq_mult_4bit: driver pushes a*b into a queue,
// an independent monitor pops and compares on every output handshake.
module tb_booth_seq_mult_4bit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] a;
   logic [3:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] product;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int accept_cyc = 0;
   int n_push = 0;
   int n_abort = 0;
   int n_out = 0;
   bit rand_stall = 1'b0;
   int exp_q[$];

   booth_seq_mult_4bit #(.N(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Monitor: every accepted output must be the oldest outstanding reference product.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         n_out++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %0d with no pending operation", $signed(product));
         end else begin
            check("product", int'($signed(product)), exp_q.pop_front());
         end
      end
   end

   task automatic stall_step();
      @(posedge clk);
      #1;
      if (rand_stall) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input int x, input int y);
      int  n;
      bit  ok;
      n = 0;
      a = 4'(x);
      b = 4'(y);
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         ok = in_ready;
         if (ok) accept_cyc = cyc;
         stall_step();
         if (ok) break;
         n++;
         if (n > 50) begin
            check("accept_timeout", 0, 1);
            break;
         end
      end
      in_valid = 1'b0;
      if (ok) begin
         exp_q.push_back(x * y);
         n_push++;
      end
   endtask

   task automatic wait_out_valid();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 50);
      check("out_valid_seen", int'(out_valid), 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 200) begin
         stall_step();
         n++;
      end
      check("drain_complete", exp_q.size(), 0);
      out_ready = 1'b1;
      stall_step();
      stall_step();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int held;
      rst_n = 1'b0;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      out_ready = 1'b1;

      // Reset state
      #12;
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_product", int'(product), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;

      // 3*5: latency and one-cycle valid pulse
      send(3, 5);
      wait_out_valid();
      check("latency_cycles", cyc - accept_cyc, 3);
      check("busy_in_done", int'(busy), 1);
      @(negedge clk);
      check("out_valid_one_cycle", int'(out_valid), 0);
      @(posedge clk);
      #1;

      // Corner operands
      send(-8, -8);
      send(-8, 7);
      send(7, -1);
      drain();

      // Back-pressure in DONE with a competing in_valid
      out_ready = 1'b0;
      send(-5, 3);
      wait_out_valid();
      held = -15;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         a = 4'd1;
         b = 4'd1;
         @(negedge clk);
         check("stall_out_valid", int'(out_valid), 1);
         check("stall_product", int'($signed(product)), held);
         check("stall_in_ready", int'(in_ready), 0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) @(negedge clk);
      check("stall_no_extra_op_valid", int'(out_valid), 0);
      check("stall_no_extra_op_busy", int'(busy), 0);
      check("stall_queue_empty", exp_q.size(), 0);
      @(posedge clk);
      #1;

      // Reset during CALC aborts the 5*6 operation
      send(5, 6);
      rst_n = 1'b0;
      exp_q.delete();
      n_abort++;
      #1;
      check("abort_out_valid", int'(out_valid), 0);
      check("abort_product", int'(product), 0);
      check("abort_busy", int'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;
      send(2, -3);
      drain();

      // Exhaustive sweep with random gaps and random out_ready stalls
      rand_stall = 1'b1;
      for (int x = -8; x < 8; x++) begin
         for (int y = -8; y < 8; y++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) stall_step();
            send(x, y);
         end
      end
      drain();
      rand_stall = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) @(negedge clk);

      check("final_queue_empty", exp_q.size(), 0);
      check("output_count", n_out, n_push - n_abort);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
